spw_route_arbiter: RTL and testbench
====================================

Name: spw_route_arbiter

Overview:
- Allocates router output ports to input ports for the SpaceWire router's COUNT-port crossbar.
- Each input presents a path-address destination extracted from its first packet byte.
- Each output runs an independent round-robin arbiter and holds the grant until the owning input reports end of packet (EOP/EEP) or goes idle past a timeout.
- Sits between the per-port receive logic and the crossbar mux; drives the mux selects and per-input grants.

Parameters:
- COUNT, 8, number of router ports (>=2).
- PW, $clog2(COUNT), port index width (derived; not overridden).
- TIMEOUT, 1024, idle cycles on an owned output before forced release (>=2).

Ports:
- clk  input  1  router clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  COUNT  input i requests the output in dest[i]. Held until gnt[i] or reject[i].
- dest  input  COUNT*PW  requested output per input; slice i is [i*PW +: PW].
- act  input  COUNT  input i forwarded one character this cycle.
- done  input  COUNT  one-cycle pulse: input i forwarded EOP/EEP.
- gnt  output  COUNT  input i currently owns an output.
- gnt_port  output  COUNT*PW  output owned by input i; valid while gnt[i].
- out_busy  output  COUNT  output o is owned.
- out_src  output  COUNT*PW  owning input of output o; crossbar select.
- reject  output  COUNT  one-cycle pulse: dest[i] >= COUNT; input must spill the packet.
- abort  output  COUNT  one-cycle pulse: input i lost its output to timeout; input must spill the rest of the packet.

Behaviour:
- Reset: all outputs 0. Round-robin pointers reset to COUNT-1, so input 0 has first priority. Idle counters 0.
- Reset mid-packet releases every output immediately. There is no abort pulse on reset.
- Eligible requester of output o: req[i]=1, gnt[i]=0, dest[i]==o, and no reject pending for i.
- Arbitration, per output o, each cycle with out_busy[o]=0:
  - Search starts at ptr[o]+1, modulo COUNT, and picks the first eligible i.
  - Registered result: out_busy, out_src, gnt[i], gnt_port[i] all assert the cycle after the request is seen. Latency is 1 cycle.
  - ptr[o] <- i on grant.
- At most one grant per input per cycle. An input has a single dest, so conflicts cannot arise.
- req deasserted before grant: the request is withdrawn with no side effects.
- Invalid destination (dest[i] >= COUNT with req[i]=1 and gnt[i]=0):
  - reject[i] pulses for 1 cycle, the cycle after.
  - While reject[i] is high, req[i] is ignored that cycle.
- Output FSM per o, states FREE and OWNED:
  - FREE -> OWNED on grant.
  - OWNED -> FREE on done[src] (registered; busy low the next cycle).
  - OWNED -> FREE on idle counter reaching TIMEOUT-1. abort[src] pulses the same cycle busy drops.
- Freed output is arbitrable in the cycle it reads FREE. Minimum gap between release and next grant is 1 cycle.
- Idle counter:
  - Clears on grant and on any cycle with act[src]=1.
  - Increments otherwise while OWNED.
  - Saturating, width $clog2(TIMEOUT+1).
- done and timeout in the same cycle: done wins, no abort.
- done or act from a non-owning input: ignored.

Decomposition:
- Package spw_router_pkg:
  - PW helper function.
  - Port-index typedef.
  - State enum {FREE, OWNED}.
  - Default TIMEOUT constant.
- Sub-module spw_rr_arb (one instance per output):
  - Inputs: COUNT-bit request vector, pointer.
  - Outputs: one-hot grant, encoded index, valid.
  - Combinational.
- Ownership FSM, timeout counter and reject logic live in spw_route_arbiter.

Test Plan:
- Single request, COUNT=8: req[2]=1, dest[2]=5 at cycle 0 -> cycle 1 gnt[2]=1, gnt_port[2]=5, out_busy[5]=1, out_src[5]=2. done[2] pulse at cycle 10 -> cycle 11 out_busy[5]=0, gnt[2]=0.
- Round-robin contention: inputs 1, 3, 6 all request output 4 continuously, each issuing done 3 cycles after its grant -> grant order 1, 3, 6, 1. Each grant follows the previous release by one cycle.
- Invalid destination: COUNT=6, req[0]=1, dest[0]=7 -> reject[0] high exactly one cycle. No out_busy change, no gnt[0].
- Timeout: TIMEOUT=16, input 3 granted output 0, act[3] never asserted -> abort[3] and out_busy[0] falling on the 16th cycle after grant. Repeat with act[3]=1 every 10 cycles -> no abort.
- done coincident with the timeout-expiry cycle -> release, abort stays 0.
- Reset mid-operation: 3 outputs owned, rst_n low for 1 cycle -> all out_busy, gnt, abort, reject 0 asynchronously. After release, input 0 wins a 0-vs-7 contention for output 2.

Source files
------------

// File: rtl/spw_router_pkg.sv
// spw_router_pkg: shared types and constants for the SpaceWire route arbiter
package spw_router_pkg;

    localparam int DEFAULT_COUNT   = 8;
    localparam int DEFAULT_TIMEOUT = 1024;

    // Port index width for a router with the given number of ports
    function automatic int pw_of(input int count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction

    typedef logic [pw_of(DEFAULT_COUNT)-1:0] port_idx_t;

    typedef enum logic {FREE, OWNED} own_state_t;

endpackage

// File: rtl/spw_rr_arb.sv
// spw_rr_arb: combinational round-robin pick, searching upward from ptr+1
module spw_rr_arb
    import spw_router_pkg::*;
#(
    parameter  int COUNT = DEFAULT_COUNT,
    localparam int PW    = pw_of(COUNT)
) (
    input  logic [COUNT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [COUNT-1:0] gnt,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    // Walk COUNT candidates starting after the last winner; first hit wins
    always_comb begin
        logic [PW-1:0] c;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= COUNT; k++) begin
            c = PW'((int'(ptr) + k) % COUNT);
            if (!valid && req[c]) begin
                valid  = 1'b1;
                idx    = c;
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spw_route_arbiter.sv
// spw_route_arbiter: allocates crossbar output ports to input ports, one round-robin arbiter per output
module spw_route_arbiter
    import spw_router_pkg::*;
#(
    parameter  int COUNT   = DEFAULT_COUNT,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int PW      = pw_of(COUNT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COUNT-1:0]    req,
    input  logic [COUNT*PW-1:0] dest,
    input  logic [COUNT-1:0]    act,
    input  logic [COUNT-1:0]    done,
    output logic [COUNT-1:0]    gnt,
    output logic [COUNT*PW-1:0] gnt_port,
    output logic [COUNT-1:0]    out_busy,
    output logic [COUNT*PW-1:0] out_src,
    output logic [COUNT-1:0]    reject,
    output logic [COUNT-1:0]    abort
);

    localparam int            IW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    own_state_t       state_q [COUNT];
    own_state_t       state_d [COUNT];
    logic [PW-1:0]    src_q   [COUNT];
    logic [PW-1:0]    src_d   [COUNT];
    logic [PW-1:0]    ptr_q   [COUNT];
    logic [PW-1:0]    ptr_d   [COUNT];
    logic [IW-1:0]    idle_q  [COUNT];
    logic [IW-1:0]    idle_d  [COUNT];
    logic [PW-1:0]    port_q  [COUNT];
    logic [PW-1:0]    port_d  [COUNT];
    logic [COUNT-1:0] elig    [COUNT];
    logic [COUNT-1:0] arb_gnt [COUNT];
    logic [PW-1:0]    arb_idx [COUNT];
    logic [COUNT-1:0] arb_valid;
    logic [COUNT-1:0] gnt_q, gnt_d, reject_q, reject_d, abort_q, abort_d;

    // Requester i competes for output o only while o is free, i holds nothing and no reject is in flight
    always_comb begin
        for (int o = 0; o < COUNT; o++) begin
            for (int i = 0; i < COUNT; i++) begin
                elig[o][i] = state_q[o] == FREE && req[i] && !gnt_q[i] && !reject_q[i]
                             && dest[i*PW +: PW] == PW'(o);
            end
        end
    end

    // Out-of-range destinations get a one-cycle reject; the pulse itself masks the next request cycle
    always_comb begin
        for (int i = 0; i < COUNT; i++) begin
            reject_d[i] = req[i] && !gnt_q[i] && !reject_q[i]
                          && {1'b0, dest[i*PW +: PW]} >= (PW+1)'(COUNT);
        end
    end

    for (genvar o = 0; o < COUNT; o++) begin : g_arb
        spw_rr_arb #(.COUNT(COUNT)) u_arb (
            .req   (elig[o]),
            .ptr   (ptr_q[o]),
            .gnt   (arb_gnt[o]),
            .idx   (arb_idx[o]),
            .valid (arb_valid[o])
        );
    end

    // Ownership FSM per output: grant from FREE, release on owner's done (wins) or idle timeout (aborts owner)
    always_comb begin
        gnt_d   = gnt_q;
        abort_d = '0;
        for (int i = 0; i < COUNT; i++) port_d[i] = port_q[i];
        for (int o = 0; o < COUNT; o++) begin
            state_d[o] = state_q[o];
            src_d[o]   = src_q[o];
            ptr_d[o]   = ptr_q[o];
            idle_d[o]  = (idle_q[o] == '1) ? idle_q[o] : idle_q[o] + 1'b1;
            if (state_q[o] == FREE) begin
                idle_d[o] = '0;
                if (arb_valid[o]) begin
                    state_d[o] = OWNED;
                    src_d[o]   = arb_idx[o];
                    ptr_d[o]   = arb_idx[o];
                end
            end else if (done[src_q[o]] || (idle_q[o] == IDLE_LAST && !act[src_q[o]])) begin
                state_d[o]        = FREE;
                gnt_d[src_q[o]]   = 1'b0;
                abort_d[src_q[o]] = !done[src_q[o]];
            end else if (act[src_q[o]]) begin
                idle_d[o] = '0;
            end
        end
        for (int i = 0; i < COUNT; i++) begin
            for (int o = 0; o < COUNT; o++) begin
                if (arb_gnt[o][i]) begin
                    gnt_d[i]  = 1'b1;
                    port_d[i] = PW'(o);
                end
            end
        end
    end

    // State register; reset frees every output and gives input 0 first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= '0;
            reject_q <= '0;
            abort_q  <= '0;
            for (int o = 0; o < COUNT; o++) begin
                state_q[o] <= FREE;
                src_q[o]   <= '0;
                ptr_q[o]   <= PW'(COUNT - 1);
                idle_q[o]  <= '0;
                port_q[o]  <= '0;
            end
        end else begin
            gnt_q    <= gnt_d;
            reject_q <= reject_d;
            abort_q  <= abort_d;
            for (int o = 0; o < COUNT; o++) begin
                state_q[o] <= state_d[o];
                src_q[o]   <= src_d[o];
                ptr_q[o]   <= ptr_d[o];
                idle_q[o]  <= idle_d[o];
                port_q[o]  <= port_d[o];
            end
        end
    end

    // Flatten per-port state onto the crossbar select and grant buses, zero when not owned
    always_comb begin
        for (int o = 0; o < COUNT; o++) begin
            out_busy[o]            = state_q[o] == OWNED;
            out_src[o*PW +: PW]    = (state_q[o] == OWNED) ? src_q[o] : '0;
            gnt_port[o*PW +: PW]   = gnt_q[o] ? port_q[o] : '0;
        end
    end

    assign gnt    = gnt_q;
    assign reject = reject_q;
    assign abort  = abort_q;

endmodule

// File: tb/tb_spw_route_arbiter.sv
// tb_spw_route_arbiter: scenario tasks with a grant scoreboard for the route arbiter
module tb_spw_route_arbiter;

    localparam int N8 = 8;
    localparam int P8 = 3;
    localparam int N6 = 6;
    localparam int P6 = 3;
    localparam int TO = 16;

    typedef struct {
        int src;
        int port;
        int cyc;
    } grant_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [N8-1:0]    req8 = '0, act8 = '0, done8 = '0;
    logic [N8*P8-1:0] dest8 = '0;
    logic [N8-1:0]    gnt8, busy8, reject8, abort8;
    logic [N8*P8-1:0] gport8, src8;

    logic [N6-1:0]    req6 = '0, act6 = '0, done6 = '0;
    logic [N6*P6-1:0] dest6 = '0;
    logic [N6-1:0]    gnt6, busy6, reject6, abort6;
    logic [N6*P6-1:0] gport6, src6;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    grant_t exp_q[$];
    logic [N8-1:0] prev_busy = '0;

    spw_route_arbiter #(.COUNT(N8), .TIMEOUT(TO)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .dest(dest8), .act(act8), .done(done8),
        .gnt(gnt8), .gnt_port(gport8), .out_busy(busy8), .out_src(src8),
        .reject(reject8), .abort(abort8)
    );

    spw_route_arbiter #(.COUNT(N6), .TIMEOUT(TO)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req6), .dest(dest6), .act(act6), .done(done6),
        .gnt(gnt6), .gnt_port(gport6), .out_busy(busy6), .out_src(src6),
        .reject(reject6), .abort(abort6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge and score any newly owned output of dut8
    task automatic step();
        grant_t e;
        int s;
        @(negedge clk);
        for (int o = 0; o < N8; o++) begin
            if (busy8[o] && !prev_busy[o]) begin
                s = int'(src8[o*P8 +: P8]);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: out=%0d src=%0d cyc=%0d, none expected", o, s, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e.port || s !== e.src || cyc !== e.cyc || gnt8[s] !== 1'b1
                        || gport8[s*P8 +: P8] !== P8'(o)) begin
                        errors++;
                        $display("FAIL grant: got out=%0d src=%0d cyc=%0d gnt=%b gnt_port=%0d, want out=%0d src=%0d cyc=%0d",
                                 o, s, cyc, gnt8[s], gport8[s*P8 +: P8], e.port, e.src, e.cyc);
                    end
                end
            end
        end
        prev_busy = busy8;
    endtask

    task automatic expect_grant(input int src, input int port, input int at);
        grant_t e;
        e.src  = src;
        e.port = port;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic set_dest8(input int i, input int p);
        dest8[i*P8 +: P8] = P8'(p);
    endtask

    task automatic wait_gnt(input int i);
        int n = 0;
        while (gnt8[i] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (gnt8[i] !== 1'b1) begin
            errors++;
            $display("FAIL wait_gnt: input %0d gnt=%b after 40 cycles, want 1", i, gnt8[i]);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        step();
        checks++;
        if ({gnt8, busy8, reject8, abort8, gport8, src8} !== '0
            || {gnt6, busy6, reject6, abort6, gport6, src6} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%h busy=%h src=%h, want all 0", gnt8, busy8, src8);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({gnt8, busy8, reject8, abort8} !== '0 || {gnt6, busy6, reject6, abort6} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: gnt=%h busy=%h, want 0", gnt8, busy8);
        end
    endtask

    task automatic test_single();
        req8[2] = 1'b1;
        set_dest8(2, 5);
        expect_grant(2, 5, cyc + 1);
        step();
        checks++;
        if (gnt8[2] !== 1'b1 || gport8[6 +: 3] !== 3'd5 || busy8 !== 8'h20 || src8[15 +: 3] !== 3'd2) begin
            errors++;
            $display("FAIL single_grant: gnt=%h gnt_port2=%0d busy=%h src5=%0d, want gnt bit2 port 5 busy 20 src 2",
                     gnt8, gport8[6 +: 3], busy8, src8[15 +: 3]);
        end
        req8[2] = 1'b0;
        repeat (9) step();
        checks++;
        if (busy8[5] !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: busy5=%b before done, want 1", busy8[5]);
        end
        done8[2] = 1'b1;
        step();
        done8[2] = 1'b0;
        checks++;
        if (busy8[5] !== 1'b0 || gnt8[2] !== 1'b0 || gport8[6 +: 3] !== 3'd0) begin
            errors++;
            $display("FAIL single_release: busy5=%b gnt2=%b, want 0 0", busy8[5], gnt8[2]);
        end
    endtask

    task automatic test_round_robin();
        int order[4] = '{1, 3, 6, 1};
        req8[1] = 1'b1;
        req8[3] = 1'b1;
        req8[6] = 1'b1;
        set_dest8(1, 4);
        set_dest8(3, 4);
        set_dest8(6, 4);
        expect_grant(1, 4, cyc + 1);
        for (int k = 0; k < 4; k++) begin
            wait_gnt(order[k]);
            repeat (3) step();
            if (k < 3) expect_grant(order[k+1], 4, cyc + 2);
            else req8 = '0;
            done8[order[k]] = 1'b1;
            step();
            done8 = '0;
            checks++;
            if (busy8[4] !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap: busy4=%b in release cycle of grant %0d, want 0", busy8[4], k);
            end
        end
    endtask

    task automatic test_reject();
        int bad[2] = '{7, 6};
        for (int k = 0; k < 2; k++) begin
            req6[0] = 1'b1;
            dest6[0 +: 3] = 3'(bad[k]);
            step();
            checks++;
            if (reject6[0] !== 1'b1 || gnt6[0] !== 1'b0 || busy6 !== '0) begin
                errors++;
                $display("FAIL reject_pulse: dest=%0d reject=%b gnt=%b busy=%h, want 1 0 0", bad[k], reject6[0], gnt6[0], busy6);
            end
            req6[0] = 1'b0;
            step();
            checks++;
            if (reject6 !== '0 || busy6 !== '0) begin
                errors++;
                $display("FAIL reject_width: dest=%0d reject=%h busy=%h, want 0 0", bad[k], reject6, busy6);
            end
        end
        req6[0] = 1'b1;
        dest6[0 +: 3] = 3'd5;
        step();
        req6[0] = 1'b0;
        checks++;
        if (reject6[0] !== 1'b0 || gnt6[0] !== 1'b1 || busy6 !== 6'h20) begin
            errors++;
            $display("FAIL top_port_valid: reject=%b gnt=%b busy=%h, want 0 1 20", reject6[0], gnt6[0], busy6);
        end
        done6[0] = 1'b1;
        step();
        done6[0] = 1'b0;
        checks++;
        if (busy6 !== '0) begin
            errors++;
            $display("FAIL top_port_release: busy=%h, want 0", busy6);
        end
    endtask

    task automatic test_timeout();
        req8[3] = 1'b1;
        set_dest8(3, 0);
        expect_grant(3, 0, cyc + 1);
        step();
        req8[3] = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            step();
            checks++;
            if (t < 16 && (busy8[0] !== 1'b1 || abort8[3] !== 1'b0)) begin
                errors++;
                $display("FAIL timeout_early: t=%0d busy0=%b abort3=%b, want 1 0", t, busy8[0], abort8[3]);
            end else if (t == 16 && (busy8[0] !== 1'b0 || abort8[3] !== 1'b1 || gnt8[3] !== 1'b0)) begin
                errors++;
                $display("FAIL timeout_fire: busy0=%b abort3=%b gnt3=%b, want 0 1 0", busy8[0], abort8[3], gnt8[3]);
            end else if (t == 17 && abort8[3] !== 1'b0) begin
                errors++;
                $display("FAIL abort_width: abort3=%b, want 0", abort8[3]);
            end
        end
    endtask

    task automatic test_activity();
        req8[3] = 1'b1;
        expect_grant(3, 0, cyc + 1);
        step();
        req8[3] = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            act8[3] = (t % 10 == 0);
            step();
            checks++;
            if (busy8[0] !== 1'b1 || abort8[3] !== 1'b0) begin
                errors++;
                $display("FAIL activity_keeps: t=%0d busy0=%b abort3=%b, want 1 0", t, busy8[0], abort8[3]);
            end
        end
        act8[3] = 1'b0;
        done8[3] = 1'b1;
        step();
        done8[3] = 1'b0;
        checks++;
        if (busy8[0] !== 1'b0 || abort8[3] !== 1'b0) begin
            errors++;
            $display("FAIL activity_release: busy0=%b abort3=%b, want 0 0", busy8[0], abort8[3]);
        end
    endtask

    task automatic test_done_at_timeout();
        req8[3] = 1'b1;
        expect_grant(3, 0, cyc + 1);
        step();
        req8[3] = 1'b0;
        repeat (15) step();
        checks++;
        if (busy8[0] !== 1'b1) begin
            errors++;
            $display("FAIL expiry_hold: busy0=%b on expiry cycle, want 1", busy8[0]);
        end
        done8[3] = 1'b1;
        step();
        done8[3] = 1'b0;
        checks++;
        if (busy8[0] !== 1'b0 || abort8[3] !== 1'b0 || gnt8[3] !== 1'b0) begin
            errors++;
            $display("FAIL done_wins: busy0=%b abort3=%b gnt3=%b, want 0 0 0", busy8[0], abort8[3], gnt8[3]);
        end
        step();
        checks++;
        if (abort8 !== '0) begin
            errors++;
            $display("FAIL done_wins_late: abort=%h, want 0", abort8);
        end
    endtask

    task automatic test_reset_mid();
        req8[1] = 1'b1;
        req8[4] = 1'b1;
        req8[5] = 1'b1;
        set_dest8(1, 2);
        set_dest8(4, 3);
        set_dest8(5, 6);
        expect_grant(1, 2, cyc + 1);
        expect_grant(4, 3, cyc + 1);
        expect_grant(5, 6, cyc + 1);
        step();
        req8 = '0;
        checks++;
        if (busy8 !== 8'b0100_1100) begin
            errors++;
            $display("FAIL three_owned: busy=%b, want 01001100", busy8);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== '0 || gnt8 !== '0 || abort8 !== '0 || reject8 !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%h gnt=%h abort=%h reject=%h, want 0", busy8, gnt8, abort8, reject8);
        end
        step();
        rst_n = 1'b1;
        req8[0] = 1'b1;
        req8[7] = 1'b1;
        set_dest8(0, 2);
        set_dest8(7, 2);
        expect_grant(0, 2, cyc + 1);
        step();
        req8 = '0;
        checks++;
        if (gnt8[0] !== 1'b1 || gnt8[7] !== 1'b0 || abort8 !== '0) begin
            errors++;
            $display("FAIL post_reset_priority: gnt=%b abort=%h, want input 0 granted", gnt8, abort8);
        end
        done8[0] = 1'b1;
        step();
        done8[0] = 1'b0;
        checks++;
        if (busy8 !== '0 || gnt8 !== '0) begin
            errors++;
            $display("FAIL final_release: busy=%h gnt=%h, want 0", busy8, gnt8);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reject();
        test_timeout();
        test_activity();
        test_done_at_timeout();
        test_reset_mid();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d grants still expected, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
